// File: rtl/seq_frame_tx.sv
// seq_frame_tx: emits one frame of an arithmetic sequence (base, base+step, ...)
// on a valid/ready stream, and publishes the frame's running sum and a count
// of completed frames once the last beat has been accepted.
module seq_frame_tx #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] base,
   input  logic [DATA_W-1:0] step,
   output logic              tvalid,
   input  logic              tready,
   output logic [DATA_W-1:0] tdata,
   output logic              tlast,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] exp_sum,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state;
   logic [LEN_W-1:0]  len_q;
   logic [DATA_W-1:0] step_q;
   logic [LEN_W-1:0]  beat;      // index of the beat currently presented
   logic [DATA_W-1:0] sum;       // sum of beats already transferred
   logic              last_beat;

   // The beat index only reaches len-1, so it never wraps even for len = 2^LEN_W-1.
   assign last_beat = (beat == len_q - 1'b1);

   // All status outputs decode straight from registered state; none of them
   // looks at tready, so tvalid cannot form a combinational path from it.
   assign tvalid = (state == SEND);
   assign tlast  = (state == SEND) && last_beat;
   assign busy   = (state == SEND) || (state == DONE);
   assign done   = (state == DONE);

   // Frame sequencing, beat generation, sum accumulation and frame counting.
   always_ff @(posedge clk) begin
      // NOTE: every register here uses <= so all of them update from the
      // values seen before the edge; a blocking '=' would let later lines see
      // the new tdata/sum and corrupt the accumulated total.
      if (rst) begin
         state     <= IDLE;
         len_q     <= '0;
         step_q    <= '0;
         beat      <= '0;
         sum       <= '0;
         tdata     <= '0;
         exp_sum   <= '0;
         frame_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A zero-length request is dropped outright.
               if (start && (len != '0)) begin
                  len_q  <= len;
                  step_q <= step;
                  tdata  <= base;
                  beat   <= '0;
                  sum    <= '0;
                  state  <= SEND;
               end
            end
            SEND: begin
               // Nothing moves until the downstream side takes the beat,
               // which keeps tdata/tlast stable while stalled.
               if (tready) begin
                  sum   <= sum + tdata;
                  tdata <= tdata + step_q;
                  beat  <= beat + 1'b1;
                  if (last_beat) begin
                     exp_sum   <= sum + tdata;
                     frame_cnt <= frame_cnt + 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               // Single-cycle completion state; start is not looked at here.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: directed frames with hand-computed sums and counts.
module tb_seq_frame_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic [31:0] base;
   logic [31:0] step;
   logic        tvalid;
   logic        tready;
   logic [31:0] tdata;
   logic        tlast;
   logic        busy;
   logic        done;
   logic [31:0] exp_sum;
   logic [15:0] frame_cnt;

   int tests = 0;
   int fails = 0;

   seq_frame_tx #(.DATA_W(32), .LEN_W(8), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .base      (base),
      .step      (step),
      .tvalid    (tvalid),
      .tready    (tready),
      .tdata     (tdata),
      .tlast     (tlast),
      .busy      (busy),
      .done      (done),
      .exp_sum   (exp_sum),
      .frame_cnt (frame_cnt)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value is wrong.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send one frame and check every beat, the completion cycle and the
   // return to idle. alt stalls every other cycle; inject holds start high
   // with junk parameters through SEND and DONE, which must be ignored.
   task automatic run_frame(input string tag, input int n, input logic [31:0] b,
                            input logic [31:0] s, input bit alt, input bit inject,
                            input logic [31:0] esum, input logic [15:0] ecnt);
      int          k;
      int          cyc;
      bit          hold_pending;
      logic [31:0] held;
      logic [31:0] kk;
      k = 0;
      cyc = 0;
      hold_pending = 1'b0;
      held = '0;
      start = 1'b1;
      len   = n[7:0];
      base  = b;
      step  = s;
      tick();
      start = inject;
      if (inject) begin
         len  = 8'd3;
         base = 32'hDEAD_0000;
         step = 32'd9;
      end
      check({tag, "_lat_valid"}, 32'(tvalid), 1);
      check({tag, "_lat_data"}, tdata, b);
      while (k < n && cyc < 2 * n + 10) begin
         tready = alt ? ((cyc % 2) == 1) : 1'b1;
         if (hold_pending) begin
            check({tag, "_hold"}, tdata, held);
            hold_pending = 1'b0;
         end
         if (!alt) check({tag, "_back2back"}, 32'(tvalid), 1);
         if (tvalid && tready) begin
            kk = k;
            check({tag, "_data"}, tdata, b + kk * s);
            check({tag, "_last"}, 32'(tlast), (k == n - 1) ? 1 : 0);
            k++;
         end else if (tvalid) begin
            held = tdata;
            hold_pending = 1'b1;
         end
         tick();
         cyc++;
      end
      if (k < n) check({tag, "_timeout_beats"}, k, n);
      tready = 1'b0;
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_busy_done"}, 32'(busy), 1);
      check({tag, "_valid_done"}, 32'(tvalid), 0);
      check({tag, "_last_done"}, 32'(tlast), 0);
      check({tag, "_sum"}, exp_sum, esum);
      check({tag, "_cnt"}, 32'(frame_cnt), 32'(ecnt));
      tick();
      start = 1'b0;
      check({tag, "_done_clr"}, 32'(done), 0);
      check({tag, "_idle_busy"}, 32'(busy), 0);
      check({tag, "_idle_valid"}, 32'(tvalid), 0);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      len    = '0;
      base   = '0;
      step   = '0;
      tready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(tvalid), 0);
      check("rst_last",  32'(tlast), 0);
      check("rst_busy",  32'(busy), 0);
      check("rst_done",  32'(done), 0);
      check("rst_data",  tdata, 0);
      check("rst_sum",   exp_sum, 0);
      check("rst_cnt",   32'(frame_cnt), 0);
      rst = 1'b0;
      tick();

      // 1+2+3+4 = 10.
      run_frame("f4", 4, 32'd1, 32'd1, 1'b0, 1'b0, 32'd10, 16'd1);
      // Same frame with stalls.
      run_frame("f4alt", 4, 32'd1, 32'd1, 1'b1, 1'b0, 32'd10, 16'd2);
      // FFFFFFFF + 0 + 1 wraps to 0.
      run_frame("wrap", 3, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 16'd3);
      // Single beat.
      run_frame("one", 1, 32'd7, 32'd5, 1'b0, 1'b0, 32'd7, 16'd4);

      // len=0 start is dropped.
      start = 1'b1;
      len   = 8'd0;
      base  = 32'd55;
      step  = 32'd1;
      tick();
      start = 1'b0;
      check("len0_busy",  32'(busy), 0);
      check("len0_valid", 32'(tvalid), 0);
      tick();
      check("len0_done",  32'(done), 0);
      check("len0_cnt",   32'(frame_cnt), 4);

      // Start held through SEND and DONE: 10 + 13 = 23, exactly one frame.
      run_frame("inject", 2, 32'd10, 32'd3, 1'b1, 1'b1, 32'd23, 16'd5);

      // Longest frame: 1+2+...+255 = 32640 = 0x7F80.
      run_frame("max", 255, 32'd1, 32'd1, 1'b0, 1'b0, 32'h7F80, 16'd6);

      // Reset after beat 2 of a len=5 frame.
      start = 1'b1;
      len   = 8'd5;
      base  = 32'd100;
      step  = 32'd1;
      tick();
      start  = 1'b0;
      tready = 1'b1;
      tick();
      tick();
      tick();
      check("abort_beat3", tdata, 32'd103);
      rst    = 1'b1;
      start  = 1'b1;
      tick();
      check("abort_valid", 32'(tvalid), 0);
      check("abort_busy",  32'(busy), 0);
      check("abort_done",  32'(done), 0);
      check("abort_cnt",   32'(frame_cnt), 0);
      check("abort_sum",   exp_sum, 0);
      check("abort_data",  tdata, 0);
      rst    = 1'b0;
      start  = 1'b0;
      tready = 1'b0;
      tick();
      check("abort_nodone", 32'(done), 0);
      tick();
      check("abort_nodone2", 32'(done), 0);

      // Recovery frame: 2 + 4 = 6.
      run_frame("after_rst", 2, 32'd2, 32'd2, 1'b0, 1'b0, 32'd6, 16'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits.
REQ-002 The block SHALL have parameter LEN_W, default 8, giving the frame-length width in bits.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the frame-counter width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: request to send one frame.
REQ-007 The block SHALL have port len, input, LEN_W bits: number of beats in the frame, sampled when start is accepted.
REQ-008 The block SHALL have port base, input, DATA_W bits: payload of the first beat, sampled when start is accepted.
REQ-009 The block SHALL have port step, input, DATA_W bits: increment between consecutive beats, sampled when start is accepted.
REQ-010 The block SHALL have port tvalid, output, 1 bit: stream valid.
REQ-011 The block SHALL have port tready, input, 1 bit: stream ready from the downstream accumulator.
REQ-012 The block SHALL have port tdata, output, DATA_W bits: stream payload.
REQ-013 The block SHALL have port tlast, output, 1 bit: marks the final beat of a frame.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse after a frame completes.
REQ-016 The block SHALL have port exp_sum, output, DATA_W bits: modulo-2^DATA_W sum of the last completed frame's payloads.
REQ-017 The block SHALL have port frame_cnt, output, CNT_W bits: number of frames completed since reset.

Function
REQ-018 The block SHALL implement states IDLE, SEND and DONE.
REQ-019 In IDLE, start=1 with len!=0 SHALL capture len, base and step, and move to SEND on the next edge.
REQ-020 In IDLE, start=1 with len=0 SHALL be ignored: no beats, no done pulse, no change to the counter.
REQ-021 start SHALL be ignored in SEND and in DONE.
REQ-022 Latency: for start accepted at edge N, tvalid SHALL be 1 from edge N+1, carrying beat 0.
REQ-023 Beat k (k = 0..len-1) SHALL carry tdata = base + k*step, modulo 2^DATA_W.
REQ-024 tlast SHALL be 1 only on beat len-1.
REQ-025 A beat SHALL transfer on an edge where tvalid=1 and tready=1.
REQ-026 Once tvalid is asserted, it SHALL stay high until that beat transfers.
REQ-027 While tvalid=1 and tready=0, tdata and tlast SHALL hold stable.
REQ-028 tvalid SHALL NOT depend combinationally on tready.
REQ-029 After each transfer that is not the last beat, the next beat SHALL be presented on the following cycle, giving 1 beat per cycle when tready is held at 1.
REQ-030 The transfer of beat len-1 SHALL move the block to DONE and drive tvalid=0 and tlast=0.
REQ-031 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-032 In DONE, exp_sum SHALL equal the frame's sum and frame_cnt SHALL have been incremented.
REQ-033 A start presented on the cycle done=1 SHALL be ignored; the earliest accepted start is in the following cycle.
REQ-034 busy SHALL be 1 exactly in SEND and DONE.
REQ-035 The sum SHALL be accumulated in an internal register and copied to exp_sum at frame end.
REQ-036 exp_sum SHALL hold its value until the next frame completes.
REQ-037 frame_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-038 len = 2^LEN_W-1 SHALL be supported; the beat counter SHALL NOT overflow.

Reset
REQ-039 On rst=1 at a rising clk edge, the block SHALL enter IDLE.
REQ-040 The same reset edge SHALL clear tvalid, tlast, busy and done to 0.
REQ-041 The same reset edge SHALL clear tdata, exp_sum, frame_cnt and all internal registers to 0.
REQ-042 A reset asserted mid-frame SHALL abort the frame with no done pulse and no counter increment.
REQ-043 After a mid-frame reset, tvalid SHALL be 0 from the edge after reset is sampled.
REQ-044 rst SHALL take priority over start and tready.

Verification
REQ-045 The bench SHALL cover: len=4, base=1, step=1, tready=1 -> tdata 1,2,3,4 on consecutive cycles; tlast with 4; done 1 cycle later; exp_sum=10; frame_cnt=1.
REQ-046 The bench SHALL cover: same frame with tready alternating 0/1 -> each beat held stable until accepted; 4 transfers; exp_sum=10; no beat lost or duplicated.
REQ-047 The bench SHALL cover: base=0xFFFFFFFF, step=1, len=3 -> tdata FFFFFFFF, 00000000, 00000001; exp_sum=0x00000000.
REQ-048 The bench SHALL cover: len=1, base=7 -> a single beat with tlast=1; exp_sum=7.
REQ-049 The bench SHALL cover: len=0 start, then start during SEND -> both ignored; frame_cnt unchanged by them.
REQ-050 The bench SHALL cover: rst=1 after beat 2 of a len=5 frame -> tvalid=0 next edge; done never pulses; frame_cnt=0; next len=2 frame completes normally.
